elbeth_host_monitor: RTL and testbench

- Sits directly downstream of the core's CSR to_host register in simulation and FPGA test builds.
- Decodes each new to_host command into one of three outcomes: test pass, test fail with an exit code, or a console character.
- Buffers console characters in a small FIFO for the host side to drain.
- Runs a cycle watchdog, so a hung program always ends in a defined DONE state.

---
 rtl/elbeth_host_pkg.sv | 36 +++
 rtl/elbeth_sync_fifo.sv | 78 +++++++
 rtl/elbeth_host_monitor.sv | 148 ++++++++++++++
 tb/tb_elbeth_host_monitor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/elbeth_host_pkg.sv
// Shared definitions for the host monitor: to_host command constants, FSM
// states and the command classifier used by the monitor and its test models.
package elbeth_host_pkg;

  localparam logic [31:0] TOHOST_PASS         = 32'd1;
  localparam logic [7:0]  CONSOLE_TAG_DEFAULT = 8'h01;

  typedef enum logic {
    HM_RUN  = 1'b0,
    HM_DONE = 1'b1
  } hm_state_e;

  typedef enum logic [1:0] {
    CMD_PASS  = 2'd0,
    CMD_FAIL  = 2'd1,
    CMD_CHAR  = 2'd2,
    CMD_OTHER = 2'd3
  } cmd_kind_e;

  // Bit 0 outranks the console tag: any odd value other than 1 is a fail.
  function automatic cmd_kind_e classify_tohost(input logic [31:0] value,
                                                input logic [7:0]  console_tag);
    cmd_kind_e kind;
    if (value == TOHOST_PASS) begin
      kind = CMD_PASS;
    end else if (value[0]) begin
      kind = CMD_FAIL;
    end else if (value[31:24] == console_tag) begin
      kind = CMD_CHAR;
    end else begin
      kind = CMD_OTHER;
    end
    return kind;
  endfunction

endpackage

// File: rtl/elbeth_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module elbeth_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter bit FWFT  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o,
  output logic             push_ok_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full || do_pop);
  assign push_ok_o = do_push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end else begin : g_reg
      logic [WIDTH-1:0] data_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          data_q <= '0;
        end else if (do_pop) begin
          data_q <= mem_q[rd_ptr_q[AW-1:0]];
        end
      end
      assign pop_data_o = data_q;
    end
  endgenerate

endmodule

// File: rtl/elbeth_host_monitor.sv
// Watches the core's to_host register: decodes pass/fail/console commands,
// queues console characters and runs a cycle watchdog that forces DONE.
module elbeth_host_monitor
  import elbeth_host_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [31:0] CYCLE_LIMIT = 32'd1000000,
  parameter logic [7:0]  CONSOLE_TAG = CONSOLE_TAG_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tohost,
  output logic        fromhost_ack,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        con_overflow,
  output logic        done,
  output logic        pass,
  output logic [30:0] exit_code,
  output logic        timeout,
  output logic [31:0] cycle_count,
  output logic        dbg_state
);

  // Console handshake: a character moves to the host on every rising edge
  // where con_valid && con_ready; con_data holds steady until it is popped.

  hm_state_e   state_q, state_d;
  logic [31:0] prev_q;
  logic        ack_q, ack_d;
  logic        pass_q, pass_d;
  logic        done_q, done_d;
  logic [30:0] exit_q, exit_d;
  logic        timeout_q, timeout_d;
  logic        ovf_q, ovf_d;
  logic [31:0] cycle_q, cycle_d;

  logic        new_cmd;
  logic        terminate;
  cmd_kind_e   kind;
  logic        con_push;
  logic        fifo_empty;
  logic        fifo_push_ok;

  assign new_cmd   = (tohost != prev_q) && (tohost != '0);
  assign kind      = classify_tohost(tohost, CONSOLE_TAG);
  assign terminate = new_cmd && ((kind == CMD_PASS) || (kind == CMD_FAIL));

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    pass_d    = pass_q;
    done_d    = done_q;
    exit_d    = exit_q;
    timeout_d = timeout_q;
    ovf_d     = ovf_q;
    cycle_d   = cycle_q;
    con_push  = 1'b0;

    if (state_q == HM_RUN) begin
      if (cycle_q != 32'hFFFF_FFFF) begin
        cycle_d = cycle_q + 32'd1;
      end

      if (new_cmd) begin
        ack_d = 1'b1;
        case (kind)
          CMD_PASS: begin
            pass_d  = 1'b1;
            done_d  = 1'b1;
            state_d = HM_DONE;
          end
          CMD_FAIL: begin
            exit_d  = tohost[31:1];
            done_d  = 1'b1;
            state_d = HM_DONE;
          end
          CMD_CHAR: begin
            con_push = 1'b1;
            if (!fifo_push_ok) begin
              ovf_d = 1'b1;
            end
          end
          default: begin
          end
        endcase
      end

      // A terminating command in the expiry cycle takes precedence.
      if ((CYCLE_LIMIT != 32'd0) && (cycle_q == CYCLE_LIMIT - 32'd1) && !terminate) begin
        timeout_d = 1'b1;
        done_d    = 1'b1;
        state_d   = HM_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HM_RUN;
      prev_q    <= '0;
      ack_q     <= 1'b0;
      pass_q    <= 1'b0;
      done_q    <= 1'b0;
      exit_q    <= '0;
      timeout_q <= 1'b0;
      ovf_q     <= 1'b0;
      cycle_q   <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= tohost;
      ack_q     <= ack_d;
      pass_q    <= pass_d;
      done_q    <= done_d;
      exit_q    <= exit_d;
      timeout_q <= timeout_d;
      ovf_q     <= ovf_d;
      cycle_q   <= cycle_d;
    end
  end

  elbeth_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .FWFT  (1'b1)
  ) u_con_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (con_push),
    .push_data_i (tohost[7:0]),
    .pop_i       (con_ready),
    .pop_data_o  (con_data),
    .empty_o     (fifo_empty),
    .push_ok_o   (fifo_push_ok)
  );

  assign con_valid    = !fifo_empty;
  assign fromhost_ack = ack_q;
  assign pass         = pass_q;
  assign done         = done_q;
  assign exit_code    = exit_q;
  assign timeout      = timeout_q;
  assign con_overflow = ovf_q;
  assign cycle_count  = cycle_q;
  assign dbg_state    = (state_q == HM_DONE);

endmodule

// File: tb/tb_elbeth_host_monitor.sv
// Bench for elbeth_host_monitor: directed scenarios plus random command
// streams, checked against a queue-based reference model of the monitor.
module tb_elbeth_host_monitor;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] WD_LIMIT = 32'd50;
  localparam logic [7:0]  TAG      = 8'h01;

  // ---------------- clock / reset / shared inputs ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tohost;
  logic        con_ready;

  always #5 clk = ~clk;

  // main instance: small FIFO, watchdog disabled
  logic        a_ack, a_valid, a_ovf, a_done, a_pass, a_timeout, a_dbg;
  logic [7:0]  a_data;
  logic [30:0] a_exit;
  logic [31:0] a_cycle;

  // watchdog instance: default FIFO, short cycle limit
  logic        w_ack, w_valid, w_ovf, w_done, w_pass, w_timeout, w_dbg;
  logic [7:0]  w_data;
  logic [30:0] w_exit;
  logic [31:0] w_cycle;

  elbeth_host_monitor #(
    .FIFO_DEPTH  (DEPTH),
    .CYCLE_LIMIT (32'd0),
    .CONSOLE_TAG (TAG)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .tohost       (tohost),
    .fromhost_ack (a_ack),
    .con_valid    (a_valid),
    .con_data     (a_data),
    .con_ready    (con_ready),
    .con_overflow (a_ovf),
    .done         (a_done),
    .pass         (a_pass),
    .exit_code    (a_exit),
    .timeout      (a_timeout),
    .cycle_count  (a_cycle),
    .dbg_state    (a_dbg)
  );

  elbeth_host_monitor #(
    .CYCLE_LIMIT (WD_LIMIT),
    .CONSOLE_TAG (TAG)
  ) u_wd (
    .clk          (clk),
    .rst          (rst),
    .tohost       (tohost),
    .fromhost_ack (w_ack),
    .con_valid    (w_valid),
    .con_data     (w_data),
    .con_ready    (con_ready),
    .con_overflow (w_ovf),
    .done         (w_done),
    .pass         (w_pass),
    .exit_code    (w_exit),
    .timeout      (w_timeout),
    .cycle_count  (w_cycle),
    .dbg_state    (w_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_ack, m_done, m_pass, m_timeout, m_ovf;
  logic [30:0] m_exit;
  logic [31:0] m_cyc, m_prev;
  logic [7:0]  exp_q[$];

  task automatic model_reset();
    m_ack = 0; m_done = 0; m_pass = 0; m_timeout = 0; m_ovf = 0;
    m_exit = '0; m_cyc = '0; m_prev = '0;
    exp_q.delete();
  endtask

  // Next state of the monitor given the inputs presented before the edge.
  task automatic model_step(input logic [31:0] th, input logic rdy);
    bit pop_now;
    bit room;
    bit term;
    pop_now = rdy && (exp_q.size() > 0);
    room    = (exp_q.size() < DEPTH) || pop_now;
    term    = 0;
    m_ack   = 0;
    if (pop_now) void'(exp_q.pop_front());
    if (!m_done) begin
      if (th != m_prev && th != 0) begin
        m_ack = 1;
        if (th == 32'd1) begin
          m_pass = 1; m_done = 1; term = 1;
        end else if (th[0]) begin
          m_exit = th[31:1]; m_done = 1; term = 1;
        end else if (th[31:24] == TAG) begin
          if (room) exp_q.push_back(th[7:0]);
          else m_ovf = 1;
        end
      end
      if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
    end
    m_prev = th;
  endtask

  task automatic compare_all();
    check("ack",      32'(a_ack),     32'(m_ack));
    check("done",     32'(a_done),    32'(m_done));
    check("pass",     32'(a_pass),    32'(m_pass));
    check("exit",     32'(a_exit),    32'(m_exit));
    check("timeout",  32'(a_timeout), 32'(m_timeout));
    check("overflow", 32'(a_ovf),     32'(m_ovf));
    check("cycles",   a_cycle,        m_cyc);
    check("valid",    32'(a_valid),   32'(exp_q.size() > 0));
    if (exp_q.size() > 0) check("con_data", 32'(a_data), 32'(exp_q[0]));
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive inputs, let one rising edge pass, compare.
  task automatic cycle(input logic [31:0] th, input logic rdy);
    tohost    = th;
    con_ready = rdy;
    model_step(th, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset(input int n, input logic [31:0] th);
    rst       = 1'b1;
    tohost    = th;
    con_ready = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare_all();
  endtask

  function automatic logic [31:0] rand_cmd(input logic [31:0] prev);
    int r;
    r = $urandom_range(0, 99);
    if (r < 30) return 32'd0;
    else if (r < 45) return prev;
    else if (r < 80) return {TAG, 16'($urandom), 7'($urandom), 1'b0};
    else if (r < 95) return {8'($urandom_range(2, 255)), 23'($urandom), 1'b0};
    else if (r < 98) return {31'($urandom), 1'b1};
    else return 32'd1;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] th;
    rst = 1'b1; tohost = '0; con_ready = 1'b0;
    model_reset();

    // reset state
    do_reset(2, 32'd0);
    check("rst_con_data", 32'(a_data), 32'd0);
    check("rst_dbg", 32'(a_dbg), 32'd0);

    // pass at cycle 10, then held: only one ack
    repeat (10) cycle(32'd0, 1'b0);
    cycle(32'd1, 1'b0);
    check("t1_ack", 32'(a_ack), 32'd1);
    check("t1_pass", 32'(a_pass), 32'd1);
    repeat (4) cycle(32'd1, 1'b0);
    check("t1_held_ack", 32'(a_ack), 32'd0);

    // fail with exit code 3; later pass ignored
    do_reset(1, 32'd0);
    cycle(32'h0000_0007, 1'b0);
    check("t2_exit", 32'(a_exit), 32'd3);
    cycle(32'd0, 1'b0);
    cycle(32'd1, 1'b0);
    check("t2_pass_ignored", 32'(a_pass), 32'd0);

    // console: bit 0 of a character command must be clear, so 'H' and 'd'
    do_reset(1, 32'd0);
    cycle(32'h0100_0048, 1'b0);
    cycle(32'd0, 1'b0);
    cycle(32'h0100_0064, 1'b0);
    repeat (2) cycle(32'd0, 1'b0);
    check("t3_head", 32'(a_data), 32'h48);
    repeat (3) cycle(32'd0, 1'b1);
    check("t3_drained", 32'(a_valid), 32'd0);

    // overflow with a 4-deep FIFO
    do_reset(1, 32'd0);
    for (int i = 0; i < 5; i++) cycle({TAG, 16'h0, 8'(8'h42 + 2 * i)}, 1'b0);
    check("t4_overflow", 32'(a_ovf), 32'd1);
    repeat (4) cycle(32'd0, 1'b1);
    check("t4_lost", 32'(a_valid), 32'd0);

    // push and pop together while full: no overflow
    do_reset(1, 32'd0);
    for (int i = 0; i < 4; i++) cycle({TAG, 16'h0, 8'(8'h42 + 2 * i)}, 1'b0);
    cycle(32'h0100_004C, 1'b1);
    check("t4_no_overflow", 32'(a_ovf), 32'd0);
    check("t4_head_after", 32'(a_data), 32'h44);

    // watchdog expiry
    do_reset(1, 32'd0);
    repeat (49) cycle(32'd0, 1'b0);
    check("wd_cycle49", w_cycle, 32'd49);
    check("wd_not_done", 32'(w_done), 32'd0);
    cycle(32'd0, 1'b0);
    check("wd_timeout", 32'(w_timeout), 32'd1);
    check("wd_done", 32'(w_done), 32'd1);
    check("wd_cycle50", w_cycle, 32'd50);
    check("wd_ack_none", 32'(w_ack), 32'd0);
    repeat (5) cycle(32'd0, 1'b0);
    check("wd_frozen", w_cycle, 32'd50);

    // pass lands in the expiry cycle
    do_reset(1, 32'd0);
    repeat (49) cycle(32'd0, 1'b0);
    cycle(32'd1, 1'b0);
    check("wd_race_pass", 32'(w_pass), 32'd1);
    check("wd_race_timeout", 32'(w_timeout), 32'd0);
    check("wd_race_done", 32'(w_done), 32'd1);

    // reset while DONE with characters queued, tohost held at 1
    do_reset(1, 32'd0);
    for (int i = 0; i < 3; i++) cycle({TAG, 16'h0, 8'(8'h60 + 2 * i)}, 1'b0);
    cycle(32'd1, 1'b0);
    do_reset(2, 32'd1);
    check("t6_empty", 32'(a_valid), 32'd0);
    check("t6_done", 32'(a_done), 32'd0);
    cycle(32'd1, 1'b0);
    check("t6_redetect", 32'(a_pass), 32'd1);

    // random command streams
    for (int round = 0; round < 10; round++) begin
      do_reset(1, 32'd0);
      th = '0;
      for (int c = 0; c < 250; c++) begin
        th = rand_cmd(th);
        cycle(th, 1'($urandom_range(0, 3) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
